// File: rtl/controle_esteira_envase_pkg.sv
// Shared state encodings and fault codes for the bottle conveyor/filler controller.
package controle_esteira_envase_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MOVER  = 3'd1,
        ENCHER = 3'd2,
        VEDAR  = 3'd3,
        SAIR   = 3'd4,
        FALHA  = 3'd5
    } estado_t;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_MOVE  = 2'b01;
    localparam logic [1:0] FC_FILL  = 2'b10;
    localparam logic [1:0] FC_ALARM = 2'b11;

endpackage

// File: rtl/controle_esteira_envase_temporizador.sv
// temporizador_ciclos: 8-bit cycle counter with synchronous clear and a terminal
// compare against a runtime limit. Holds at 255 instead of wrapping.
module temporizador_ciclos (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [7:0] limit,
    output logic [7:0] count,
    output logic       terminal
);

    logic [7:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= 8'd0;
        end else if (clear) begin
            count_reg <= 8'd0;
        end else if (count_reg != 8'hFF) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign count    = count_reg;
    assign terminal = (count_reg == limit);

endmodule

// File: rtl/controle_esteira_envase.sv
// Conveyor/filler controller: moves, fills, hands the bottle to the sealer via
// gar/pos, ejects it and pulses cq. Faults latch until the operator clears them.
module controle_esteira_envase
    import controle_esteira_envase_pkg::*;
#(
    parameter int MOVE_TIMEOUT = 100,
    parameter int FILL_MAX     = 50,
    parameter int EXIT_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       sensor_pos,
    input  logic       level_full,
    input  logic       done,
    input  logic       alarme,
    input  logic       clear,
    output logic       motor,
    output logic       valve,
    output logic       gar,
    output logic       pos,
    output logic       cq,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [7:0] contagem
);

    localparam logic [7:0] LIM_MOVE = 8'(MOVE_TIMEOUT - 1);
    localparam logic [7:0] LIM_FILL = 8'(FILL_MAX - 1);
    localparam logic [7:0] LIM_EXIT = 8'(EXIT_CYCLES - 1);

    estado_t    state_reg, state_next;
    logic [1:0] fault_code_reg, fault_code_next;
    logic       cq_reg;
    logic [7:0] contagem_reg;

    logic       timer_clear;
    logic [7:0] timer_limit;
    logic [7:0] timer_count;
    logic       timer_terminal;
    logic       entering_sair;

    // The timer only needs a limit in states that can time out; others never hit it.
    always_comb begin
        timer_limit = 8'hFF;
        case (state_reg)
            MOVER:   timer_limit = LIM_MOVE;
            ENCHER:  timer_limit = LIM_FILL;
            SAIR:    timer_limit = LIM_EXIT;
            default: timer_limit = 8'hFF;
        endcase
    end

    assign timer_clear = (state_next != state_reg);

    temporizador_ciclos u_temporizador (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .limit    (timer_limit),
        .count    (timer_count),
        .terminal (timer_terminal)
    );

    always_comb begin
        state_next      = state_reg;
        fault_code_next = fault_code_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = MOVER;
            end
            MOVER: begin
                if (sensor_pos) begin
                    state_next = ENCHER;
                end else if (timer_terminal) begin
                    state_next      = FALHA;
                    fault_code_next = FC_MOVE;
                end
            end
            ENCHER: begin
                if (level_full) begin
                    state_next = VEDAR;
                end else if (timer_terminal) begin
                    state_next      = FALHA;
                    fault_code_next = FC_FILL;
                end
            end
            VEDAR: begin
                // Alarm wins over done so a faulted bottle never reaches SAIR.
                if (alarme) begin
                    state_next      = FALHA;
                    fault_code_next = FC_ALARM;
                end else if (done) begin
                    state_next = SAIR;
                end
            end
            SAIR: begin
                if (timer_terminal) state_next = start ? MOVER : IDLE;
            end
            FALHA: begin
                if (clear) begin
                    state_next      = IDLE;
                    fault_code_next = FC_NONE;
                end
            end
            default: begin
                state_next      = IDLE;
                fault_code_next = FC_NONE;
            end
        endcase
    end

    assign entering_sair = (state_next == SAIR) && (state_reg != SAIR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            fault_code_reg <= FC_NONE;
            cq_reg         <= 1'b0;
            contagem_reg   <= 8'd0;
        end else begin
            state_reg      <= state_next;
            fault_code_reg <= fault_code_next;
            cq_reg         <= entering_sair;
            if (entering_sair && (contagem_reg != 8'hFF)) begin
                contagem_reg <= contagem_reg + 8'd1;
            end
        end
    end

    assign motor      = (state_reg == MOVER) || (state_reg == SAIR);
    assign valve      = (state_reg == ENCHER);
    assign gar        = (state_reg == VEDAR);
    assign pos        = (state_reg == VEDAR);
    assign fault      = (state_reg == FALHA);
    assign cq         = cq_reg;
    assign fault_code = fault_code_reg;
    assign contagem   = contagem_reg;

endmodule

// File: tb/tb_controle_esteira_envase.sv
// Directed bench for controle_esteira_envase: normal bottles, a dozen run,
// move/fill timeouts, sealer alarm and asynchronous reset during filling.
module tb_controle_esteira_envase;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       sensor_pos = 1'b0;
    logic       level_full = 1'b0;
    logic       done = 1'b0;
    logic       alarme = 1'b0;
    logic       clear = 1'b0;
    logic       motor, valve, gar, pos, cq, fault;
    logic [1:0] fault_code;
    logic [7:0] contagem;

    int n_checks = 0;
    int n_fail   = 0;
    int cq_seen  = 0;
    int cq_base  = 0;
    int exp_cnt  = 0;

    controle_esteira_envase dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sensor_pos (sensor_pos),
        .level_full (level_full),
        .done       (done),
        .alarme     (alarme),
        .clear      (clear),
        .motor      (motor),
        .valve      (valve),
        .gar        (gar),
        .pos        (pos),
        .cq         (cq),
        .fault      (fault),
        .fault_code (fault_code),
        .contagem   (contagem)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cq === 1'b1) cq_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_actuators"}, {28'd0, motor, valve, gar, pos}, 32'd0);
        check({tag, "_cq_fault"}, {30'd0, cq, fault}, 32'd0);
    endtask

    // Entered with the DUT just in MOVER; runs one complete bottle.
    task automatic run_bottle(input int n_move, input int n_fill, input int n_seal,
                              input bit drop_start, input string tag);
        for (int i = 0; i < n_move; i++) begin
            check({tag, "_mover_motor"}, {30'd0, motor, valve}, 32'd2);
            sensor_pos = (i == n_move - 1);
            step();
        end
        sensor_pos = 1'b0;
        for (int i = 0; i < n_fill; i++) begin
            check({tag, "_encher_valve"}, {30'd0, motor, valve}, 32'd1);
            level_full = (i == n_fill - 1);
            step();
        end
        level_full = 1'b0;
        for (int i = 0; i < n_seal; i++) begin
            check({tag, "_vedar_garpos"}, {29'd0, motor, gar, pos}, 32'd3);
            if (drop_start) start = 1'b0;
            done = (i == n_seal - 1);
            step();
        end
        done = 1'b0;
        exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_sair_motor"}, {30'd0, motor, gar}, 32'd2);
            check({tag, "_sair_cq"}, {31'd0, cq}, {31'd0, (i == 0)});
            check({tag, "_sair_contagem"}, {24'd0, contagem}, exp_cnt);
            step();
        end
        check({tag, "_after_motor"}, {31'd0, motor}, {31'd0, start});
        check({tag, "_after_fault"}, {29'd0, valve, gar, fault}, 32'd0);
        $display("bottle %s done: contagem=%0d motor=%0b", tag, contagem, motor);
    endtask

    initial begin
        // 1: reset with random inputs
        for (int i = 0; i < 3; i++) begin
            {start, sensor_pos, level_full, done, alarme, clear} = 6'($urandom);
            step();
            check_idle_outputs("reset_hold");
            check("reset_code", {22'd0, fault_code, contagem}, 32'd0);
        end
        {sensor_pos, level_full, done, alarme, clear} = 5'd0;
        start = 1'b1;
        reset = 1'b1;
        check_idle_outputs("idle_after_release");
        step();
        check("first_mover_motor", {31'd0, motor}, 32'd1);
        $display("test1 reset/start: motor=%0b", motor);

        // 2: one normal bottle
        run_bottle(5, 3, 2, 1'b0, "t2");
        check("t2_contagem", {24'd0, contagem}, 32'd1);

        // 3: fresh dozen, start dropped during the last VEDAR
        reset = 1'b0;
        #1;
        check_idle_outputs("t3_reset");
        step();
        reset = 1'b1;
        step();
        exp_cnt = 0;
        cq_base = cq_seen;
        for (int b = 1; b <= 12; b++) begin
            run_bottle(2, 2, 1, (b == 12), $sformatf("t3_b%0d", b));
        end
        check("t3_cq_pulses", cq_seen - cq_base, 32'd12);
        check("t3_contagem", {24'd0, contagem}, 32'd12);
        step();
        check_idle_outputs("t3_stays_idle");

        // 4: move timeout after exactly 100 cycles; clear outside FALHA ignored
        start = 1'b1;
        step();
        for (int i = 0; i < 100; i++) begin
            check("t4_mover", {30'd0, motor, fault}, 32'd2);
            clear = (i == 0);
            step();
        end
        clear = 1'b0;
        check("t4_fault", {29'd0, fault, fault_code}, 32'h5);
        check("t4_motor_off", {31'd0, motor}, 32'd0);
        step();
        check("t4_start_ignored", {31'd0, fault}, 32'd1);
        start = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t4_cleared", {29'd0, fault, fault_code}, 32'd0);
        check("t4_contagem", {24'd0, contagem}, 32'd12);
        $display("test4 move timeout cleared: contagem=%0d", contagem);

        // fill timeout after 50 cycles in ENCHER
        start = 1'b1;
        step();
        sensor_pos = 1'b1;
        step();
        sensor_pos = 1'b0;
        for (int i = 0; i < 50; i++) begin
            check("fill_valve", {30'd0, valve, fault}, 32'd2);
            step();
        end
        check("fill_fault", {29'd0, fault, fault_code}, 32'h6);
        check("fill_valve_off", {31'd0, valve}, 32'd0);
        start = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("fill_cleared", {29'd0, fault, fault_code}, 32'd0);

        // 5: alarme and done together in VEDAR
        cq_base = cq_seen;
        start = 1'b1;
        step();
        sensor_pos = 1'b1;
        step();
        sensor_pos = 1'b0;
        level_full = 1'b1;
        step();
        level_full = 1'b0;
        check("t5_vedar", {30'd0, gar, pos}, 32'd3);
        alarme = 1'b1;
        done = 1'b1;
        step();
        {alarme, done} = 2'b00;
        check("t5_alarm_fault", {29'd0, fault, fault_code}, 32'h7);
        check("t5_no_cq", {31'd0, cq}, 32'd0);
        step();
        check("t5_no_cq_later", cq_seen - cq_base, 32'd0);
        check("t5_contagem", {24'd0, contagem}, 32'd12);
        start = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        $display("test5 alarm: fault_code cleared to %0d", fault_code);

        // 6: asynchronous reset while filling
        start = 1'b1;
        step();
        sensor_pos = 1'b1;
        step();
        sensor_pos = 1'b0;
        check("t6_valve_open", {31'd0, valve}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_valve_async", {31'd0, valve}, 32'd0);
        check("t6_contagem_async", {24'd0, contagem}, 32'd0);
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        check_idle_outputs("t6_idle");
        check("t6_contagem", {22'd0, fault_code, contagem}, 32'd0);
        $display("test6 async reset: valve=%0b contagem=%0d", valve, contagem);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
